// File: rtl/mem_access_unit.sv
// mem_access_unit: turns byte/halfword/word load and store requests into accesses on a
// word-wide memory port. Sub-word stores use a read-modify-write; loads extract and extend.
//
// Ports:
//   mau_clk, mau_rst                   clock, synchronous active-high reset
//   mau_req_valid / mau_req_ready      request handshake
//   mau_req_write/size/signed/addr/wdata  request fields (store data right-aligned)
//   mau_resp_valid/rdata/err           one-cycle completion pulse with load data / error flag
//   mau_mem_MemRead/MemWrite           word-memory read and write enables
//   mau_mem_address/Write              word-aligned address and full write word
//   mau_mem_Read                       combinational read data from memory
module mem_access_unit #(
    parameter int unsigned ADDR_LIMIT = 4096
) (
    input  logic        mau_clk,
    input  logic        mau_rst,
    input  logic        mau_req_valid,
    output logic        mau_req_ready,
    input  logic        mau_req_write,
    input  logic [1:0]  mau_req_size,
    input  logic        mau_req_signed,
    input  logic [31:0] mau_req_addr,
    input  logic [31:0] mau_req_wdata,
    output logic        mau_resp_valid,
    output logic [31:0] mau_resp_rdata,
    output logic        mau_resp_err,
    output logic        mau_mem_MemRead,
    output logic        mau_mem_MemWrite,
    output logic [31:0] mau_mem_address,
    output logic [31:0] mau_mem_Write,
    input  logic [31:0] mau_mem_Read
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRd   = 2'd1;
    localparam logic [1:0] StWr   = 2'd2;
    localparam logic [1:0] StResp = 2'd3;

    localparam logic [1:0] SizeByte = 2'b00;
    localparam logic [1:0] SizeHalf = 2'b01;
    localparam logic [1:0] SizeWord = 2'b10;

    logic [1:0]  state_q, state_d;
    logic        write_q, write_d;
    logic [1:0]  size_q, size_d;
    logic        signed_q, signed_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] word_q, word_d;       // merged word for a sub-word store
    logic        resp_valid_q, resp_valid_d;
    logic        resp_err_q, resp_err_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;

    logic        req_err;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_data;
    logic [31:0] merged;

    // Request legality: bad size, misalignment, or out of range.
    always_comb begin
        req_err = 1'b0;
        case (mau_req_size)
            SizeHalf: req_err = mau_req_addr[0];
            SizeWord: req_err = (mau_req_addr[1:0] != 2'b00);
            SizeByte: req_err = 1'b0;
            default:  req_err = 1'b1;
        endcase
        if (mau_req_addr >= 32'(ADDR_LIMIT)) begin
            req_err = 1'b1;
        end
    end

    // Load extraction and store lane merge, both working on the word read in RD.
    always_comb begin
        rd_byte = mau_mem_Read[{addr_q[1:0], 3'b000} +: 8];
        rd_half = addr_q[1] ? mau_mem_Read[31:16] : mau_mem_Read[15:0];
        case (size_q)
            SizeByte: load_data = {{24{signed_q & rd_byte[7]}}, rd_byte};
            SizeHalf: load_data = {{16{signed_q & rd_half[15]}}, rd_half};
            default:  load_data = mau_mem_Read;
        endcase
        merged = mau_mem_Read;
        if (size_q == SizeByte) begin
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        end
    end

    always_comb begin
        state_d      = state_q;
        write_d      = write_q;
        size_d       = size_q;
        signed_d     = signed_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        word_d       = word_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = 32'h0;
        case (state_q)
            StIdle: begin
                if (mau_req_valid) begin
                    write_d  = mau_req_write;
                    size_d   = mau_req_size;
                    signed_d = mau_req_signed;
                    addr_d   = mau_req_addr;
                    wdata_d  = mau_req_wdata;
                    if (req_err) begin
                        state_d      = StResp;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else if (mau_req_write && (mau_req_size == SizeWord)) begin
                        state_d = StWr;
                    end else begin
                        state_d = StRd;
                    end
                end
            end
            StRd: begin
                if (write_q) begin
                    word_d  = merged;
                    state_d = StWr;
                end else begin
                    resp_valid_d = 1'b1;
                    resp_rdata_d = load_data;
                    state_d      = StResp;
                end
            end
            StWr: begin
                resp_valid_d = 1'b1;
                state_d      = StResp;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge mau_clk) begin
        if (mau_rst) begin
            state_q      <= StIdle;
            write_q      <= 1'b0;
            size_q       <= 2'b00;
            signed_q     <= 1'b0;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            word_q       <= 32'h0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'h0;
        end else begin
            state_q      <= state_d;
            write_q      <= write_d;
            size_q       <= size_d;
            signed_q     <= signed_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            word_q       <= word_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    // Memory-side outputs are gated by reset so an in-flight WR never writes.
    always_comb begin
        mau_req_ready    = (state_q == StIdle) && !mau_rst;
        mau_mem_MemRead  = (state_q == StRd) && !mau_rst;
        mau_mem_MemWrite = (state_q == StWr) && !mau_rst;
        mau_mem_address  = 32'h0;
        mau_mem_Write    = 32'h0;
        if (((state_q == StRd) || (state_q == StWr)) && !mau_rst) begin
            mau_mem_address = {addr_q[31:2], 2'b00};
        end
        if ((state_q == StWr) && !mau_rst) begin
            mau_mem_Write = (size_q == SizeWord) ? wdata_q : word_q;
        end
    end

    assign mau_resp_valid = resp_valid_q;
    assign mau_resp_err   = resp_err_q;
    assign mau_resp_rdata = resp_rdata_q;

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter ADDR_LIMIT, default 4096, byte-address bound; requests at or above it are errors.
REQ-002 mau_clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 mau_rst  input  1  reset, synchronous and active-high.
REQ-004 mau_req_valid  input  1  request present.
REQ-005 mau_req_ready  output  1  unit can accept a request.
REQ-006 mau_req_write  input  1  1 = store, 0 = load.
REQ-007 mau_req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-008 mau_req_signed  input  1  load sign-extends when 1, zero-extends when 0.
REQ-009 mau_req_addr  input  32  byte address.
REQ-010 mau_req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-011 mau_resp_valid  output  1  one-cycle completion pulse.
REQ-012 mau_resp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-013 mau_resp_err  output  1  request rejected; valid only with mau_resp_valid.
REQ-014 mau_mem_MemRead  output  1  word-memory read enable.
REQ-015 mau_mem_MemWrite  output  1  word-memory write enable, sampled by memory at rising edge.
REQ-016 mau_mem_address  output  32  word-aligned byte address ({addr[31:2],2'b00}).
REQ-017 mau_mem_Write  output  32  full word to write.
REQ-018 mau_mem_Read  input  32  combinational read data from memory, valid same cycle as MemRead.

Function
REQ-019 FSM states IDLE, RD, WR, RESP; mau_req_ready = 1 only in IDLE with mau_rst low.
REQ-020 Accept on valid && ready at cycle t; latch write, size, signed, addr, wdata; inputs ignored until return to IDLE.
REQ-021 Error if size = 11, or half with addr[0] = 1, or word with addr[1:0] != 00, or addr >= ADDR_LIMIT; error goes IDLE -> RESP, no memory access, resp at t+1 with err = 1, rdata = 0.
REQ-022 Load: IDLE -> RD -> RESP; in RD MemRead = 1, word captured at end of RD; resp at t+2.
REQ-023 Word store: IDLE -> WR -> RESP; in WR MemWrite = 1, Write = wdata; resp at t+2.
REQ-024 Byte/half store: IDLE -> RD -> WR -> RESP; RD captures old word, WR writes old word with only the addressed lanes replaced; resp at t+3.
REQ-025 Byte lanes little-endian: byte k = bits [8k+7:8k]; halfword at addr[1] = 1 occupies [31:16].
REQ-026 Load extraction: selected byte/half moved to bit 0, upper bits filled with its MSB if signed, else 0; word loads unmodified.
REQ-027 RESP lasts exactly one cycle, always -> IDLE; no response backpressure.
REQ-028 Outside RD: MemRead = 0; outside WR: MemWrite = 0; address and Write = 0 in IDLE and RESP.
REQ-029 Back-to-back: new request accepted in the IDLE cycle immediately following RESP; throughput max one request per 3 cycles (load/word store).
REQ-030 Address wrap not applicable: addresses >= ADDR_LIMIT rejected per REQ-021, never aliased.

Reset
REQ-031 mau_rst high at a rising edge: state -> IDLE, all latched fields -> 0, resp_valid, resp_err, resp_rdata -> 0.
REQ-032 While mau_rst high: req_ready = 0, MemRead = 0, MemWrite = 0, address = 0, Write = 0 (combinationally forced).
REQ-033 Reset mid-operation aborts the access; no response pulse, and no memory write is issued after reset asserts, even from WR.

Verification
REQ-034 Word store addr 0x10 data 0xDEADBEEF accepted cycle t -> MemWrite = 1 at t+1 with address 0x10; resp_valid at t+2, err 0; word load 0x10 returns 0xDEADBEEF at t+2.
REQ-035 Memory word 0x10 = 0x11223344; byte store 0xAA to 0x11 -> MemRead t+1, MemWrite t+2 with Write 0x1122AA44, resp t+3.
REQ-036 Memory word 0x20 = 0x80FF7F01; signed byte load 0x22 -> 0xFFFFFFFF; unsigned -> 0x000000FF; signed half load 0x22 -> 0xFFFF80FF; signed byte load 0x20 -> 0x00000001.
REQ-037 Half load addr 0x13, word store addr 0x16, size 11, load addr 4096 -> each resp at t+1 with err = 1, rdata 0, MemRead/MemWrite never asserted.
REQ-038 mau_rst asserted during WR of a byte store -> MemWrite low that cycle, target word unchanged, no resp_valid, ready = 1 first cycle after reset deasserts.
REQ-039 req_valid held high continuously with three word loads -> accepts at t, t+3, t+6; ready low in all non-IDLE cycles.
